// File: rtl/iter_alu.sv
// Execution unit driven by the ALU decoder's alucontrol code. Single-cycle
// add/sub/logic/compare; shifts iterate one bit per clock to keep the barrel shifter out.
module iter_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alucontrol,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SRA  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_result;
    logic                 r_illegal;
    logic [SHAMT_W-1:0]   r_count;
    logic [3:0]           r_op;

    logic [WIDTH-1:0]     w_aluResult;
    logic                 w_isShift;
    logic                 w_illegal;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [WIDTH-1:0]     w_shiftStep;

    assign w_shamt = b[SHAMT_W-1:0];

    // Single-cycle results are formed straight from the inputs and latched at accept.
    always_comb begin
        w_aluResult = '0;
        w_isShift   = 1'b0;
        w_illegal   = 1'b0;
        case (alucontrol)
            OP_ADD:  w_aluResult = a + b;
            OP_SUB:  w_aluResult = a - b;
            OP_AND:  w_aluResult = a & b;
            OP_OR:   w_aluResult = a | b;
            OP_XOR:  w_aluResult = a ^ b;
            OP_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_aluResult = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SRA, OP_SRL, OP_SLL: w_isShift = 1'b1;
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_shiftStep = r_result;
        case (r_op)
            OP_SLL:  w_shiftStep = {r_result[WIDTH-2:0], 1'b0};
            OP_SRL:  w_shiftStep = {1'b0, r_result[WIDTH-1:1]};
            OP_SRA:  w_shiftStep = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
            default: w_shiftStep = r_result;
        endcase
    end

    // The result register doubles as the shift register while iterating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_result  <= '0;
            r_illegal <= 1'b0;
            r_count   <= '0;
            r_op      <= OP_ADD;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op <= alucontrol;
                        if (w_isShift) begin
                            r_result  <= a;
                            r_count   <= w_shamt;
                            r_illegal <= 1'b0;
                            r_state   <= (w_shamt == '0) ? DONE : SHIFT;
                        end else begin
                            r_result  <= w_aluResult;
                            r_illegal <= w_illegal;
                            r_state   <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    r_result <= w_shiftStep;
                    r_count  <= r_count - SHAMT_W'(1);
                    if (r_count == SHAMT_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign zero      = (r_result == '0);
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: a vector table of whole transactions plus
// hand-written backpressure and mid-shift reset sequences.
module tb_iter_alu;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [3:0]  aluControl;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        outValid;
    logic        outReady;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expResult;
        logic        expZero;
        logic        expIllegal;
        int          expLatency;
    } vec_t;

    vec_t vectors[18];

    iter_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .alucontrol (aluControl),
        .a          (opA),
        .b          (opB),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Waits (bounded) for in_ready at a falling edge, then presents a request.
    task automatic issueRequest(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        while (inReady !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) checkOutput("in_ready timeout", 32'(inReady), 32'd1);
        aluControl = ctrl;
        opA        = a;
        opB        = b;
        inValid    = 1'b1;
        @(posedge clk);
        #1;
        inValid    = 1'b0;
        aluControl = 4'b0011;
        opA        = 32'hDEAD_BEEF;
        opB        = 32'h0000_0007;
    endtask

    task automatic waitResult(output int latency);
        latency = 0;
        do begin
            @(negedge clk);
            latency++;
        end while (outValid !== 1'b1 && latency < 100);
    endtask

    task automatic drainResult(input string name);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        @(negedge clk);
        checkOutput({name, " in_ready after handshake"}, 32'(inReady), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int latency;
        issueRequest(v.ctrl, v.a, v.b);
        waitResult(latency);
        checkOutput({v.name, " latency"}, 32'(latency), 32'(v.expLatency));
        checkOutput({v.name, " result"}, result, v.expResult);
        checkOutput({v.name, " zero"}, 32'(zero), 32'(v.expZero));
        checkOutput({v.name, " illegal"}, 32'(illegal), 32'(v.expIllegal));
        drainResult(v.name);
    endtask

    initial begin
        int latency;

        vectors[0]  = '{"add",        4'b0000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1};
        vectors[1]  = '{"sub equal",  4'b0001, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0, 1};
        vectors[2]  = '{"slt neg",    4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1};
        vectors[3]  = '{"sltu big",   4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1};
        vectors[4]  = '{"sra 4",      4'b0100, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, 5};
        vectors[5]  = '{"srl 4",      4'b0110, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 5};
        vectors[6]  = '{"sll 31",     4'b0111, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 32};
        vectors[7]  = '{"sll shamt0", 4'b0111, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1};
        vectors[8]  = '{"and",        4'b0010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 1};
        vectors[9]  = '{"or",         4'b0011, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0, 1};
        vectors[10] = '{"illegal c",  4'b1100, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1, 1};
        vectors[11] = '{"add wrap",   4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1};
        vectors[12] = '{"sub borrow", 4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};
        vectors[13] = '{"srl 8",      4'b0110, 32'hFFFF_0000, 32'h0000_0008, 32'h00FF_FF00, 1'b0, 1'b0, 9};
        vectors[14] = '{"sra pos 3",  4'b0100, 32'h4000_0000, 32'h0000_0003, 32'h0800_0000, 1'b0, 1'b0, 4};
        vectors[15] = '{"slt pos",    4'b0101, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1'b1, 1'b0, 1};
        vectors[16] = '{"sltu small", 4'b1000, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0001, 1'b0, 1'b0, 1};
        vectors[17] = '{"illegal f",  4'b1111, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1'b1, 1};

        rst_n      = 1'b0;
        inValid    = 1'b0;
        outReady   = 1'b0;
        aluControl = 4'b0000;
        opA        = '0;
        opB        = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", 32'(inReady), 32'd1);
        checkOutput("reset out_valid", 32'(outValid), 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset zero", 32'(zero), 32'd1);
        checkOutput("reset illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vectors[i]);
        end

        // Backpressure: result must hold while a competing request is ignored.
        issueRequest(4'b1001, 32'hFF00_FF00, 32'h0FF0_0FF0);
        waitResult(latency);
        checkOutput("xor latency", 32'(latency), 32'd1);
        aluControl = 4'b0000;
        opA        = 32'h0000_0001;
        opB        = 32'h0000_0001;
        inValid    = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checkOutput("xor held result", result, 32'hF0F0_F0F0);
            checkOutput("xor in_ready low", 32'(inReady), 32'd0);
            checkOutput("xor out_valid held", 32'(outValid), 32'd1);
            @(negedge clk);
        end
        inValid = 1'b0;
        checkOutput("xor final result", result, 32'hF0F0_F0F0);
        drainResult("xor");
        checkOutput("xor no phantom op", 32'(outValid), 32'd0);

        // Reset arriving between clock edges in the middle of a 10-bit sra.
        issueRequest(4'b0100, 32'h8000_0000, 32'h0000_000A);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset in_ready", 32'(inReady), 32'd1);
        checkOutput("async reset out_valid", 32'(outValid), 32'd0);
        checkOutput("async reset result", result, 32'd0);
        checkOutput("async reset zero", 32'(zero), 32'd1);
        checkOutput("async reset illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post reset out_valid", 32'(outValid), 32'd0);
        applyStimulus(vectors[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Execution unit that consumes the 4-bit alucontrol code produced by the ALU decoder and performs the selected operation on two operands.
- Add/sub/logic/compare ops complete in one cycle. Shifts run iteratively at one bit per cycle to save LUTs on the iCE40.
- Sits between the register-read stage and writeback of the multi-cycle core.
- Uses a valid/ready handshake on both input and output and holds one operation at a time.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept an operation.
- alucontrol  input  4  operation code (encoding below).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; shifts use b[SHAMT_W-1:0] as shamt.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- illegal  output  1  alucontrol was not a defined code.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, illegal=0, shift counter=0. Reset mid-shift or mid-hold abandons the operation; no output handshake occurs for it.
- alucontrol encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sra
  - 0101 slt (signed), 0110 srl, 0111 sll, 1000 sltu, 1001 xor
  - 1010-1111 illegal
- Accept: transfer occurs when in_valid && in_ready. in_ready=1 only in IDLE. alucontrol, a and b are captured at accept; later input changes are ignored.
- States: IDLE, SHIFT, DONE.
- IDLE, on accept, for non-shift codes:
  - result computed from captured operands, go to DONE.
  - out_valid=1 the cycle after accept (latency 1).
- IDLE, on accept, for shift codes (0100/0110/0111):
  - load shift register with a and counter with shamt.
  - shamt==0: go directly to DONE with result=a (latency 1).
  - otherwise go to SHIFT.
- SHIFT: each cycle shift the register by 1 bit and decrement the counter.
  - sll: zero fill from the LSB.
  - srl: zero fill from the MSB.
  - sra: replicate bit WIDTH-1 into the MSB.
  - When the counter reaches 0 after the shift, go to DONE. out_valid rises exactly 1+shamt cycles after accept.
- DONE: out_valid=1; result, zero and illegal are held stable until out_valid && out_ready. On that cycle go to IDLE; in_ready=1 the next cycle. No back-to-back accept in the same cycle as output handshake.
- Arithmetic rules:
  - add/sub are modulo 2^WIDTH; carry and overflow are discarded.
  - slt/sltu give result = {WIDTH-1 zeros, lt}.
- Illegal code: result=0, zero=1, illegal=1, latency 1. Otherwise illegal=0 in DONE.
- zero is combinationally derived from the registered result.
- in_valid while not in IDLE has no effect. The producer must hold the request until in_ready.

Test Plan:
- Reset then add: a=0x0000_0005, b=0x0000_0003, alucontrol=0000 accepted at cycle T -> out_valid at T+1, result=0x0000_0008, zero=0, illegal=0. Handshake with out_ready=1 -> in_ready=1 at T+2.
- Sub/compare: a=7, b=7, code 0001 -> result=0, zero=1. a=0xFFFF_FFFF, b=1, code 0101 -> result=1. Same operands, code 1000 -> result=0.
- Shifts:
  - a=0x8000_0000, b=4, code 0100 -> out_valid exactly 5 cycles after accept, result=0xF800_0000.
  - Same a and b, code 0110 -> 0x0800_0000.
  - a=1, b=31, code 0111 -> 0x8000_0000 after 32 cycles.
  - b=0x20 (shamt 0) -> result=a at latency 1.
- Backpressure: xor a=0xFF00_FF00, b=0x0FF0_0FF0 with out_ready=0 for 6 cycles -> result=0xF0F0_F0F0 held stable, in_ready=0 throughout, new in_valid ignored. Output handshake at cycle 7.
- Illegal code 1100 -> result=0, zero=1, illegal=1 at latency 1. Next legal op clears illegal.
- Reset mid-operation: assert rst_n=0 asynchronously during cycle 3 of a 10-bit sra -> outputs immediately return to reset values without waiting for a clock edge. The following add executes normally with latency 1.
